rf_write_master: RTL and testbench

RF_WRITE_MASTER -- requirements
Module: rf_write_master

---
 rtl/rf_write_master_if.sv | 45 ++++
 rtl/rf_write_master.sv | 106 ++++++++++
 tb/tb_rf_write_master.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rf_write_master_if.sv
// Bundles the two result channels, the register-file write port and the bypass
// query port of rf_write_master. The design drives through "master"; its environment uses "slave".
interface rf_write_master_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_wa;
    logic [DATA_WIDTH-1:0] alu_wd;

    logic                  we;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;

    logic [ADDR_WIDTH-1:0] ra0;
    logic [ADDR_WIDTH-1:0] ra1;
    logic                  hit0;
    logic                  hit1;
    logic [DATA_WIDTH-1:0] fwd0;
    logic [DATA_WIDTH-1:0] fwd1;

    modport master (
        input  mem_valid, mem_wa, mem_wd,
        input  alu_valid, alu_wa, alu_wd,
        input  ra0, ra1,
        output mem_ready, alu_ready,
        output we, wa, wd,
        output hit0, hit1, fwd0, fwd1
    );

    modport slave (
        output mem_valid, mem_wa, mem_wd,
        output alu_valid, alu_wa, alu_wd,
        output ra0, ra1,
        input  mem_ready, alu_ready,
        input  we, wa, wd,
        input  hit0, hit1, fwd0, fwd1
    );
endinterface

// File: rtl/rf_write_master.sv
// Write-back queue merging load and ALU results into one register-file write port.
// Define RF_WB_BYPASS_EN to build the pending-write bypass lookup; otherwise hit/fwd are tied to 0.
module rf_write_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic            clk,
    input  logic            rstn,
    rf_write_master_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] rptr_reg;
    logic [PTR_W-1:0] wptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic             pop;
    logic             mem_push;
    logic             alu_push;
    logic [CNT_W-1:0] free;
    logic [PTR_W-1:0] alu_slot;

    // The head retires every cycle it is presented, so its slot counts as free.
    assign pop  = (count_reg != '0);
    assign free = CNT_W'(DEPTH) - count_reg + CNT_W'(pop);

    assign bus.mem_ready = (free >= CNT_W'(1));
    assign bus.alu_ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !bus.mem_valid);

    // Writes to r0 complete the handshake but never occupy a slot.
    assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_wa != '0);
    assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_wa != '0);
    assign alu_slot = wptr_reg + PTR_W'(mem_push);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            rptr_reg  <= rptr_reg + PTR_W'(pop);
            wptr_reg  <= wptr_reg + PTR_W'(mem_push) + PTR_W'(alu_push);
            count_reg <= count_reg + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            addr_mem[wptr_reg] <= bus.mem_wa;
            data_mem[wptr_reg] <= bus.mem_wd;
        end
        if (alu_push) begin
            addr_mem[alu_slot] <= bus.alu_wa;
            data_mem[alu_slot] <= bus.alu_wd;
        end
    end

    assign bus.we = pop;
    assign bus.wa = pop ? addr_mem[rptr_reg] : '0;
    assign bus.wd = pop ? data_mem[rptr_reg] : '0;

`ifdef RF_WB_BYPASS_EN
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_lookup
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;
        logic [DATA_WIDTH-1:0] fwd;

        assign ra = (gi == 0) ? bus.ra0 : bus.ra1;

        // Scan oldest to youngest so the last match left standing is the youngest.
        always_comb begin
            logic [PTR_W-1:0] idx;
            hit = 1'b0;
            fwd = '0;
            idx = '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx = rptr_reg + PTR_W'(i);
                if ((CNT_W'(i) < count_reg) && (ra != '0) && (addr_mem[idx] == ra)) begin
                    hit = 1'b1;
                    fwd = data_mem[idx];
                end
            end
        end
    end

    assign bus.hit0 = g_lookup[0].hit;
    assign bus.hit1 = g_lookup[1].hit;
    assign bus.fwd0 = g_lookup[0].fwd;
    assign bus.fwd1 = g_lookup[1].fwd;
`else
    logic unused_ra;
    assign unused_ra = ^{bus.ra0, bus.ra1};

    assign bus.hit0 = 1'b0;
    assign bus.hit1 = 1'b0;
    assign bus.fwd0 = '0;
    assign bus.fwd1 = '0;
`endif
endmodule

// File: tb/tb_rf_write_master.sv
// Directed and randomized checks of rf_write_master against a queue-based reference model.
module tb_rf_write_master;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk;
    logic rstn;
    int   checks;
    int   passes;
    ent_t q[$];

    rf_write_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rf_write_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic mv, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd,
                         input logic av, input logic [AW-1:0] awa, input logic [DW-1:0] awd);
        bus.mem_valid = mv;
        bus.mem_wa    = mwa;
        bus.mem_wd    = mwd;
        bus.alu_valid = av;
        bus.alu_wa    = awa;
        bus.alu_wd    = awd;
    endtask

    task automatic lookup(input logic [AW-1:0] ra, output logic h, output logic [DW-1:0] f);
        h = 1'b0;
        f = '0;
`ifdef RF_WB_BYPASS_EN
        foreach (q[i]) begin
            if (ra != '0 && q[i].a == ra) begin
                h = 1'b1;
                f = q[i].d;
            end
        end
`endif
    endtask

    // Compare every output against the model mid-cycle, then advance one clock.
    task automatic cyc();
        int            n;
        int            free;
        logic          e_mr;
        logic          e_ar;
        logic          h0;
        logic          h1;
        logic [DW-1:0] f0;
        logic [DW-1:0] f1;
        logic          mx;
        logic          ax;
        @(negedge clk);
        n    = q.size();
        free = DEPTH - n + ((n != 0) ? 1 : 0);
        e_mr = (free >= 1);
        e_ar = (free >= 2) || (free >= 1 && !bus.mem_valid);
        lookup(bus.ra0, h0, f0);
        lookup(bus.ra1, h1, f1);
        chk("we",        64'(bus.we),        64'(n != 0));
        chk("wa",        64'(bus.wa),        (n != 0) ? 64'(q[0].a) : 64'd0);
        chk("wd",        64'(bus.wd),        (n != 0) ? 64'(q[0].d) : 64'd0);
        chk("mem_ready", 64'(bus.mem_ready), 64'(e_mr));
        chk("alu_ready", 64'(bus.alu_ready), 64'(e_ar));
        chk("hit0",      64'(bus.hit0),      64'(h0));
        chk("hit1",      64'(bus.hit1),      64'(h1));
        chk("fwd0",      64'(bus.fwd0),      64'(f0));
        chk("fwd1",      64'(bus.fwd1),      64'(f1));
        mx = bus.mem_valid && e_mr;
        ax = bus.alu_valid && e_ar;
        @(posedge clk);
        if (n != 0) void'(q.pop_front());
        if (mx && bus.mem_wa != '0) q.push_back('{a: bus.mem_wa, d: bus.mem_wd});
        if (ax && bus.alu_wa != '0) q.push_back('{a: bus.alu_wa, d: bus.alu_wd});
        $display("cycle t=%0t mv=%0b av=%0b we=%0b wa=%0d wd=%0h depth=%0d",
                 $time, bus.mem_valid, bus.alu_valid, bus.we, bus.wa, bus.wd, q.size());
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rstn   = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        bus.ra0 = 5'd3;
        bus.ra1 = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",   64'(bus.we),   64'd0);
        chk("rst_wa",   64'(bus.wa),   64'd0);
        chk("rst_wd",   64'(bus.wd),   64'd0);
        chk("rst_hit0", 64'(bus.hit0), 64'd0);
        chk("rst_hit1", 64'(bus.hit1), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU write into an empty queue
        drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h11);
        cyc();
        idle(3);

        // Both channels together: mem first, then alu
        drive(1'b1, 5'd5, 32'hA, 1'b1, 5'd6, 32'hB);
        cyc();
        idle(4);

        // Saturate both channels
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            cyc();
        end
        idle(6);

        // r0 writes are accepted and dropped
        bus.ra0 = 5'd0;
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFF);
        cyc();
        idle(3);

        // Two pending writes to r7, youngest forwarded
        bus.ra0 = 5'd7;
        drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        cyc();
        idle(4);

        // Randomized traffic with a small address space to provoke bypass hits
        for (int i = 0; i < 400; i++) begin
            bus.ra0 = 5'($urandom_range(0, 7));
            bus.ra1 = 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            cyc();
        end
        idle(6);

        // Reset in mid-operation with three entries pending
        bus.ra0 = 5'd9;
        drive(1'b1, 5'd9, 32'h91, 1'b1, 5'd10, 32'hA1);
        cyc();
        drive(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC1);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk("pre_rst_we", 64'(bus.we), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_we",   64'(bus.we),   64'd0);
        chk("mid_rst_wa",   64'(bus.wa),   64'd0);
        chk("mid_rst_wd",   64'(bus.wd),   64'd0);
        chk("mid_rst_hit0", 64'(bus.hit0), 64'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        idle(5);

        // Accepting again right after reset release
        drive(1'b1, 5'd13, 32'hD1, 1'b0, '0, '0);
        cyc();
        idle(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
